// File: rtl/alu_issue_ctrl.sv
// Issue controller sitting between a request handshake and a combinational ALU:
// latches one operation, drives the ALU, captures its result and holds it until consumed.
module alu_issue_ctrl #(
  parameter int word_size = 32
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4:0]           req_op,
  input  logic [word_size-1:0] req_a,
  input  logic [word_size-1:0] req_b,
  output logic [word_size-1:0] alu_a,
  output logic [word_size-1:0] alu_b,
  output logic [4:0]           alu_sel,
  input  logic [word_size-1:0] alu_low,
  input  logic [word_size-1:0] alu_high,
  output logic [word_size-1:0] z_low,
  output logic [word_size-1:0] z_high,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic                 div_zero,
  output logic                 illegal_op,
  output logic [15:0]          ops_done
);

  // state   | meaning
  // IDLE    | ready for a request
  // DRIVE   | operands on the ALU, one settle cycle
  // CAPTURE | register ALU result (div-by-zero override applied here)
  // HOLD    | result presented, waiting for z_ready
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

  localparam logic [4:0] OP_DIV     = 5'd2;
  localparam logic [4:0] OP_MAX_LEG = 5'd5;

  state_t                 state_q, state_d;
  logic [word_size-1:0]   a_q, a_d, b_q, b_d;
  logic [4:0]             sel_q, sel_d;
  logic [word_size-1:0]   z_low_q, z_low_d, z_high_q, z_high_d;
  logic                   div_zero_q, div_zero_d, illegal_q, illegal_d;
  logic [15:0]            ops_done_q, ops_done_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    z_low_d    = z_low_q;
    z_high_d   = z_high_q;
    div_zero_d = div_zero_q;
    illegal_d  = illegal_q;
    ops_done_d = ops_done_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d = req_a;
          b_d = req_b;
          if (req_op <= OP_MAX_LEG) begin
            sel_d   = req_op;
            state_d = DRIVE;
          end else begin
            // alu_sel keeps the last legal opcode so the ALU input does not glitch
            illegal_d  = 1'b1;
            z_low_d    = '0;
            z_high_d   = '0;
            div_zero_d = 1'b0;
            state_d    = HOLD;
          end
        end
      end
      DRIVE: state_d = CAPTURE;
      CAPTURE: begin
        illegal_d = 1'b0;
        if (sel_q == OP_DIV && b_q == '0) begin
          z_low_d    = '1;
          z_high_d   = '0;
          div_zero_d = 1'b1;
        end else begin
          z_low_d    = alu_low;
          z_high_d   = alu_high;
          div_zero_d = 1'b0;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (z_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      z_low_q    <= '0;
      z_high_q   <= '0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      z_low_q    <= z_low_d;
      z_high_q   <= z_high_d;
      div_zero_q <= div_zero_d;
      illegal_q  <= illegal_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign z_valid    = (state_q == HOLD);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;
  assign z_low      = z_low_q;
  assign z_high     = z_high_q;
  assign div_zero   = div_zero_q;
  assign illegal_op = illegal_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed corner cases plus randomized traffic,
// expected results pushed at issue time and popped by an independent monitor.
module tb_alu_issue_ctrl;

  logic        clk, clear, req_valid, req_ready, z_valid, z_ready, div_zero, illegal_op;
  logic [4:0]  req_op, alu_sel;
  logic [31:0] req_a, req_b, alu_a, alu_b, alu_low, alu_high, z_low, z_high;
  logic [15:0] ops_done;

  alu_issue_ctrl #(.word_size(32)) dut (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_low(alu_low), .alu_high(alu_high),
    .z_low(z_low), .z_high(z_high), .z_valid(z_valid), .z_ready(z_ready),
    .div_zero(div_zero), .illegal_op(illegal_op), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo, hi, a, b;
    logic        dz, ill;
    logic [4:0]  sel;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          force_rdy = 1'b0;
  logic [4:0]  last_sel = 5'd0;
  logic [15:0] mdl_cnt = 16'd0;

  // Behavioural ALU: high word is carry/borrow, remainder, or the complement for logic ops.
  function automatic logic [63:0] alu_fn(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] t;
    logic [31:0] lo, hi;
    case (s)
      5'd0: begin t = {1'b0, a} + {1'b0, b}; lo = t[31:0]; hi = {31'd0, t[32]}; end
      5'd1: begin t = {1'b0, a} - {1'b0, b}; lo = t[31:0]; hi = {31'd0, t[32]}; end
      5'd2: begin
        if (b != 0) begin lo = a / b; hi = a % b; end
        else begin lo = 32'h1234_5678; hi = 32'h9ABC_DEF0; end
      end
      5'd3: begin lo = a & b; hi = ~lo; end
      5'd4: begin lo = a | b; hi = ~lo; end
      5'd5: begin lo = a ^ b; hi = ~lo; end
      default: begin lo = 32'hDEAD_BEEF; hi = 32'hDEAD_BEEF; end
    endcase
    return {hi, lo};
  endfunction

  assign {alu_high, alu_low} = alu_fn(alu_sel, alu_a, alu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    e.a = a; e.b = b; e.acc = 0;
    if (op > 5) begin
      e.lo = 0; e.hi = 0; e.dz = 0; e.ill = 1; e.sel = last_sel; e.lat = 1;
    end else begin
      r = alu_fn(op, a, b);
      e.ill = 0; e.sel = op; e.lat = 3;
      if (op == 5'd2 && b == 0) begin e.lo = 32'hFFFF_FFFF; e.hi = 0; e.dz = 1; end
      else begin e.lo = r[31:0]; e.hi = r[63:32]; e.dz = 0; end
    end
    return e;
  endfunction

  initial begin
    cyc = 0;
    forever begin @(posedge clk); cyc++; end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!force_rdy) z_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: samples 2 time units after the falling edge so all negedge drives have settled.
  initial begin
    bit   v_prev, hs_prev, have_cur;
    exp_t cur;
    v_prev = 0; hs_prev = 0; have_cur = 0;
    forever begin
      @(negedge clk); #2;
      if (hs_prev) begin
        chk("no_bypass_zvalid", z_valid, 0);
        chk("no_bypass_ready", req_ready, 1);
      end
      hs_prev = 0;
      if (z_valid && !v_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_zvalid", 1, 0);
          have_cur = 0;
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          chk("latency", cyc - cur.acc + 1, cur.lat);
          chk("z_low", z_low, cur.lo);
          chk("z_high", z_high, cur.hi);
          chk("div_zero", div_zero, cur.dz);
          chk("illegal_op", illegal_op, cur.ill);
          chk("alu_sel", alu_sel, cur.sel);
          chk("alu_a", alu_a, cur.a);
          chk("alu_b", alu_b, cur.b);
          chk("ops_done_at_valid", ops_done, mdl_cnt);
        end
      end else if (z_valid && have_cur) begin
        chk("hold_z_low", z_low, cur.lo);
        chk("hold_z_high", z_high, cur.hi);
        chk("hold_flags", {div_zero, illegal_op}, {cur.dz, cur.ill});
        chk("hold_ready_low", req_ready, 0);
      end
      if (z_valid && z_ready) begin
        hs_prev = 1;
        mdl_cnt = mdl_cnt + 16'd1;
      end
      v_prev = z_valid;
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("timeout_req_ready", 0, 1);
    end else begin
      req_valid = 1; req_op = op; req_a = a; req_b = b;
      if (push) begin
        e = ref_model(op, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        if (op <= 5) last_sel = op;
      end
      @(negedge clk);
      req_valid = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && req_ready && !z_valid) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("timeout_drain", 0, 1);
  endtask

  initial begin
    logic [31:0] held;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          n;
    clear = 1; req_valid = 1; req_op = 0; req_a = 32'd1; req_b = 32'd2; z_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_zvalid", z_valid, 0);
    chk("rst_z", {z_low, z_high}, 0);
    chk("rst_flags", {div_zero, illegal_op}, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_alu", {alu_a, alu_b, 27'd0, alu_sel}, 0);
    clear = 0; req_valid = 0;
    @(negedge clk);
    chk("clear_valid_not_accepted", req_ready, 1);

    // clear while in CAPTURE discards the operation
    issue(5'd0, 32'd33, 32'd44, 0);
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("midop_ready", req_ready, 1);
    chk("midop_zvalid", z_valid, 0);
    chk("midop_z", {z_low, z_high}, 0);
    chk("midop_alu", {alu_a, alu_b, 27'd0, alu_sel}, 0);
    chk("midop_ops_done", ops_done, 0);
    last_sel = 0;

    issue(5'd0, 32'd5, 32'd7, 1);
    drain();
    chk("add_retained_idle", z_low, 32'd12);
    chk("add_ops_done", ops_done, 16'd1);
    issue(5'd2, 32'd100, 32'd0, 1);
    issue(5'd3, 32'hF0, 32'h3C, 1);
    drain();
    chk("and_result", z_low, 32'h30);
    chk("and_div_zero", div_zero, 0);
    issue(5'd9, 32'd11, 32'd22, 1);
    drain();
    chk("illegal_sel_kept", alu_sel, 5'd3);

    // backpressure: hold z_ready low, poke ignored requests
    force_rdy = 1; z_ready = 0;
    issue(5'd1, 32'd1000, 32'd1, 1);
    n = 0;
    while (!z_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_zvalid_seen", z_valid, 1);
    held = z_low;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_zvalid", z_valid, 1);
      chk("bp_z_low", z_low, held);
      chk("bp_ready", req_ready, 0);
      req_valid = 1; req_op = 5'd4; req_a = $urandom; req_b = $urandom;
    end
    @(negedge clk);
    req_valid = 0; z_ready = 1;
    @(negedge clk);
    chk("bp_release_idle", req_ready, 1);
    chk("bp_z_low_after", z_low, 32'd999);
    force_rdy = 0;

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      issue(op, a, b, 1);
    end
    drain();
    chk("ops_done_total", ops_done, mdl_cnt);

    // counter wrap: preload the counter then complete one more operation
    force dut.ops_done_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.ops_done_q;
    mdl_cnt = 16'hFFFF;
    chk("wrap_preload", ops_done, 16'hFFFF);
    issue(5'd5, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1);
    drain();
    chk("wrap_zero", ops_done, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
